// File: rtl/l1_rd_data_port.sv
// L1 read return path: issues BRAM reads against a credit pool, aligns returning data with
// its stream id through a latency pipeline and hands it to the AFU through an in-order FIFO.
module l1_rd_data_port #(
    parameter int unsigned width        = 64,
    parameter int unsigned nstrms_width = 6,
    parameter int unsigned lat          = 2,
    parameter int unsigned depth        = 4,
    parameter int unsigned cnt_width    = $clog2(depth + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_addr_v,
    output logic                    i_addr_r,
    input  logic [nstrms_width-1:0] i_addr_sid,
    output logic                    o_bram_re,
    input  logic [width-1:0]        i_bram_data,
    output logic                    o_rd_v,
    input  logic                    o_rd_r,
    output logic [width-1:0]        o_rd_data,
    output logic [nstrms_width-1:0] o_rd_sid,
    output logic [cnt_width-1:0]    o_credits
);

    localparam int unsigned aw = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [aw-1:0] last_idx = aw'(depth - 1);
    localparam logic [cnt_width-1:0] full_credits = cnt_width'(depth);

    logic [cnt_width-1:0]    credits_q, credits_d;
    logic [lat-1:0]          pv_q, pv_d;
    logic [nstrms_width-1:0] ps_q [lat];
    logic [nstrms_width-1:0] ps_d [lat];
    logic [aw-1:0]           wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic                    wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic [width-1:0]        dmem_q [depth];
    logic [width-1:0]        dmem_d [depth];
    logic [nstrms_width-1:0] smem_q [depth];
    logic [nstrms_width-1:0] smem_d [depth];

    logic issue, push, pop, empty;

    // Issue is also blocked while reset is asserted so no BRAM read escapes mid-reset.
    always_comb begin
        i_addr_r  = (credits_q != '0);
        issue     = i_addr_v & i_addr_r & ~reset;
        o_bram_re = issue;
        push      = pv_q[lat-1];
        empty     = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
        o_rd_v    = ~empty;
        pop       = o_rd_v & o_rd_r;
        o_rd_data = dmem_q[rd_idx_q];
        o_rd_sid  = smem_q[rd_idx_q];
        o_credits = credits_q;
    end

    // Stage lat-1 lines up with i_bram_data for the read issued lat cycles earlier.
    always_comb begin
        pv_d    = '0;
        ps_d    = ps_q;
        pv_d[0] = issue;
        ps_d[0] = i_addr_sid;
        for (int i = 1; i < int'(lat); i++) begin
            pv_d[i] = pv_q[i-1];
            ps_d[i] = ps_q[i-1];
        end
    end

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_wrap_d = wr_wrap_q;
        rd_idx_d  = rd_idx_q;
        rd_wrap_d = rd_wrap_q;
        dmem_d    = dmem_q;
        smem_d    = smem_q;
        if (push) begin
            dmem_d[wr_idx_q] = i_bram_data;
            smem_d[wr_idx_q] = ps_q[lat-1];
            wr_idx_d         = (wr_idx_q == last_idx) ? '0 : wr_idx_q + 1'b1;
            wr_wrap_d        = wr_wrap_q ^ (wr_idx_q == last_idx);
        end
        if (pop) begin
            rd_idx_d  = (rd_idx_q == last_idx) ? '0 : rd_idx_q + 1'b1;
            rd_wrap_d = rd_wrap_q ^ (rd_idx_q == last_idx);
        end
    end

    // Credits cover in-flight reads plus buffered entries, so a push never finds the FIFO full.
    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - cnt_width'(1);
        end else if (pop && !issue) begin
            credits_d = credits_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q <= full_credits;
            pv_q      <= '0;
            wr_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_wrap_q <= 1'b0;
            for (int i = 0; i < int'(lat); i++) begin
                ps_q[i] <= '0;
            end
            for (int i = 0; i < int'(depth); i++) begin
                dmem_q[i] <= '0;
                smem_q[i] <= '0;
            end
        end else begin
            credits_q <= credits_d;
            pv_q      <= pv_d;
            ps_q      <= ps_d;
            wr_idx_q  <= wr_idx_d;
            wr_wrap_q <= wr_wrap_d;
            rd_idx_q  <= rd_idx_d;
            rd_wrap_q <= rd_wrap_d;
            dmem_q    <= dmem_d;
            smem_q    <= smem_d;
        end
    end

endmodule

// File: tb/tb_l1_rd_data_port.sv
// Directed bench for l1_rd_data_port: reset, single read, back-pressure, throughput, reset
// while reads are in flight.
module tb_l1_rd_data_port;

    localparam int unsigned W   = 64;
    localparam int unsigned SW  = 6;
    localparam int unsigned LAT = 2;
    localparam int unsigned D   = 4;
    localparam int unsigned CW  = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          i_addr_v;
    logic          i_addr_r;
    logic [SW-1:0] i_addr_sid;
    logic          o_bram_re;
    logic [W-1:0]  i_bram_data;
    logic          o_rd_v;
    logic          o_rd_r;
    logic [W-1:0]  o_rd_data;
    logic [SW-1:0] o_rd_sid;
    logic [CW-1:0] o_credits;

    // BRAM model: data chosen at issue time appears two cycles later.
    logic [W-1:0] issue_dat, d1, d2, tog;
    logic         force_tog;

    int checks;
    int failures;
    int n_issued;

    l1_rd_data_port #(
        .width       (W),
        .nstrms_width(SW),
        .lat         (LAT),
        .depth       (D),
        .cnt_width   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_addr_v   (i_addr_v),
        .i_addr_r   (i_addr_r),
        .i_addr_sid (i_addr_sid),
        .o_bram_re  (o_bram_re),
        .i_bram_data(i_bram_data),
        .o_rd_v     (o_rd_v),
        .o_rd_r     (o_rd_r),
        .o_rd_data  (o_rd_data),
        .o_rd_sid   (o_rd_sid),
        .o_credits  (o_credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1  <= issue_dat;
        d2  <= d1;
        tog <= ~tog;
    end

    assign i_bram_data = force_tog ? tog : d2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        i_addr_v   = 1'b0;
        i_addr_sid = '0;
        o_rd_r     = 1'b0;
        issue_dat  = '0;
        d1         = '0;
        d2         = '0;
        tog        = 64'h5555_5555_5555_5555;
        force_tog  = 1'b0;

        #1;
        check_eq("rst_rd_v", 64'(o_rd_v), 64'd0);
        check_eq("rst_bram_re", 64'(o_bram_re), 64'd0);
        check_eq("rst_addr_r", 64'(i_addr_r), 64'd1);
        check_eq("rst_credits", 64'(o_credits), 64'd4);
        check_eq("rst_data", o_rd_data, 64'd0);
        check_eq("rst_sid", 64'(o_rd_sid), 64'd0);
        #11 reset = 1'b0;
        step();
        check_eq("post_rst_addr_r", 64'(i_addr_r), 64'd1);
        check_eq("post_rst_credits", 64'(o_credits), 64'd4);

        // Single read: issue in cycle 0, data at cycle 2, returned in cycle 3.
        i_addr_v   = 1'b1;
        i_addr_sid = 6'd5;
        issue_dat  = 64'hAB;
        o_rd_r     = 1'b1;
        #1;
        check_eq("single_bram_re", 64'(o_bram_re), 64'd1);
        step();
        i_addr_v  = 1'b0;
        issue_dat = '0;
        #1;
        check_eq("single_c1_credits", 64'(o_credits), 64'd3);
        check_eq("single_c1_rd_v", 64'(o_rd_v), 64'd0);
        check_eq("single_c1_bram_re", 64'(o_bram_re), 64'd0);
        step();
        check_eq("single_c2_rd_v", 64'(o_rd_v), 64'd0);
        step();
        check_eq("single_c3_rd_v", 64'(o_rd_v), 64'd1);
        check_eq("single_c3_data", o_rd_data, 64'hAB);
        check_eq("single_c3_sid", 64'(o_rd_sid), 64'd5);
        check_eq("single_c3_credits", 64'(o_credits), 64'd3);
        step();
        check_eq("single_c4_credits", 64'(o_credits), 64'd4);
        check_eq("single_c4_rd_v", 64'(o_rd_v), 64'd0);

        // Back-pressure: continuous requests, AFU stalled.
        o_rd_r   = 1'b0;
        i_addr_v = 1'b1;
        n_issued = 0;
        for (int c = 0; c < 8; c++) begin
            i_addr_sid = SW'(10 + n_issued);
            issue_dat  = 64'(32'h100 + n_issued);
            #1;
            if (o_bram_re) n_issued++;
            step();
        end
        check_eq("bp_issues", 64'(n_issued), 64'd4);
        check_eq("bp_addr_r", 64'(i_addr_r), 64'd0);
        check_eq("bp_credits", 64'(o_credits), 64'd0);
        i_addr_v = 1'b0;
        #1;
        check_eq("bp_stall_v", 64'(o_rd_v), 64'd1);
        check_eq("bp_stall_data", o_rd_data, 64'h100);
        check_eq("bp_stall_sid", 64'(o_rd_sid), 64'd10);
        step();
        check_eq("bp_stall2_data", o_rd_data, 64'h100);
        check_eq("bp_stall2_sid", 64'(o_rd_sid), 64'd10);
        o_rd_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("bp_drain_v", 64'(o_rd_v), 64'd1);
            check_eq("bp_drain_data", o_rd_data, 64'(32'h100 + k));
            check_eq("bp_drain_sid", 64'(o_rd_sid), 64'(10 + k));
            if (k == 0) check_eq("bp_addr_r_pop", 64'(i_addr_r), 64'd0);
            if (k == 1) begin
                check_eq("bp_addr_r_after", 64'(i_addr_r), 64'd1);
                check_eq("bp_credits_after", 64'(o_credits), 64'd1);
            end
            step();
        end
        check_eq("bp_empty", 64'(o_rd_v), 64'd0);
        check_eq("bp_credits_end", 64'(o_credits), 64'd4);

        // Throughput: 16 back-to-back issues, data = sid*3, AFU always ready.
        for (int c = 0; c < 22; c++) begin
            if (c < 16) begin
                i_addr_v   = 1'b1;
                i_addr_sid = SW'(c);
                issue_dat  = 64'(3 * c);
            end else begin
                i_addr_v  = 1'b0;
                issue_dat = '0;
            end
            #1;
            if (c < 16) check_eq("tp_addr_r", 64'(i_addr_r), 64'd1);
            if (c >= 3 && c < 19) begin
                check_eq("tp_rd_v", 64'(o_rd_v), 64'd1);
                check_eq("tp_data", o_rd_data, 64'(3 * (c - 3)));
                check_eq("tp_sid", 64'(o_rd_sid), 64'(c - 3));
            end else begin
                check_eq("tp_idle_v", 64'(o_rd_v), 64'd0);
            end
            if (c >= 3 && c <= 16) check_eq("tp_credits_one", 64'(o_credits), 64'd1);
            step();
        end
        check_eq("tp_credits_end", 64'(o_credits), 64'd4);

        // Reset with two reads in flight and two entries buffered.
        o_rd_r = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_addr_v   = 1'b1;
            i_addr_sid = SW'(40 + c);
            issue_dat  = 64'(32'h500 + c);
            step();
        end
        check_eq("mf_rd_v", 64'(o_rd_v), 64'd1);
        check_eq("mf_data", o_rd_data, 64'h500);
        check_eq("mf_credits", 64'(o_credits), 64'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("mf_async_rd_v", 64'(o_rd_v), 64'd0);
        check_eq("mf_async_bram_re", 64'(o_bram_re), 64'd0);
        check_eq("mf_async_addr_r", 64'(i_addr_r), 64'd1);
        check_eq("mf_async_credits", 64'(o_credits), 64'd4);
        check_eq("mf_async_data", o_rd_data, 64'd0);
        @(posedge clk);
        #3;
        i_addr_v  = 1'b0;
        force_tog = 1'b1;
        reset     = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check_eq("mf_after_rd_v", 64'(o_rd_v), 64'd0);
            check_eq("mf_after_credits", 64'(o_credits), 64'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
